// File: rtl/fpu_la_pkg.sv
// Shared definitions for the LA-to-FPU bridge: LA bit map, FPU opcode and
// rounding encodings, FSM state codes and exception-flag positions.
package fpu_la_pkg;

    localparam int LA_W = 128;

    // Command word (effective LA input) bit positions
    localparam int CMD_A_LSB   = 0;
    localparam int CMD_B_LSB   = 32;
    localparam int CMD_C_LSB   = 64;
    localparam int CMD_OP_LSB  = 96;
    localparam int CMD_RM_LSB  = 100;
    localparam int CMD_REQ_BIT = 103;
    localparam int CMD_CLR_BIT = 104;

    // Response word bit positions
    localparam int RSP_RES_LSB   = 0;
    localparam int RSP_FLAGS_LSB = 32;
    localparam int RSP_ACK_BIT   = 37;
    localparam int RSP_BUSY_BIT  = 38;
    localparam int RSP_ERR_BIT   = 39;
    localparam int RSP_OVR_BIT   = 40;
    localparam int RSP_LAT_LSB   = 48;

    typedef enum logic [3:0] {
        FPU_OP_ADD  = 4'd0,
        FPU_OP_SUB  = 4'd1,
        FPU_OP_MUL  = 4'd2,
        FPU_OP_DIV  = 4'd3,
        FPU_OP_SQRT = 4'd4,
        FPU_OP_FMA  = 4'd5
    } fpu_op_e;

    typedef enum logic [2:0] {
        FPU_RM_RNE = 3'd0,
        FPU_RM_RTZ = 3'd1,
        FPU_RM_RDN = 3'd2,
        FPU_RM_RUP = 3'd3,
        FPU_RM_RMM = 3'd4
    } fpu_rm_e;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_ISSUE = 2'd1;
    localparam state_t ST_WAIT  = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

    localparam int FLAG_NV = 4;
    localparam int FLAG_DZ = 3;
    localparam int FLAG_OF = 2;
    localparam int FLAG_UF = 1;
    localparam int FLAG_NX = 0;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/la_toggle_sync.sv
// Toggle-handshake edge detector: remembers the last seen toggle level and
// flags a new event whenever the incoming level differs from it.
module la_toggle_sync (
    input  logic clk,
    input  logic rst_l,
    input  logic tog_in,
    output logic pulse
);

    logic req_q;
    logic req_d;

    // The level is tracked every cycle, whether or not the event is consumed
    always_comb begin
        req_d = tog_in;
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            req_q <= 1'b0;
        end else begin
            req_q <= req_d;
        end
    end

    assign pulse = tog_in ^ req_q;

endmodule

// File: rtl/fpu_la_bridge.sv
// LA command responder: samples a toggled command from the management core,
// runs one FPU operation and publishes result, flags, status and latency.
module fpu_la_bridge
    import fpu_la_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         rst_l,
    input  logic [127:0] la_data_in,
    input  logic [127:0] la_oenb,
    output logic [127:0] la_data_out,
    output logic         fpu_valid,
    input  logic         fpu_ready,
    output logic [3:0]   fpu_op,
    output logic [2:0]   fpu_rm,
    output logic [31:0]  fpu_a,
    output logic [31:0]  fpu_b,
    output logic [31:0]  fpu_c,
    input  logic         fpu_done,
    input  logic [31:0]  fpu_result,
    input  logic [4:0]   fpu_flags
);

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    logic [LA_W-1:0] eff;
    logic            req_pulse;
    logic            clr_req;
    logic            busy;
    logic [7:0]      lat_inc;
    logic            unused_eff;

    state_t      state_q, state_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] c_q, c_d;
    logic [3:0]  op_q, op_d;
    logic [2:0]  rm_q, rm_d;
    logic        valid_q, valid_d;
    logic [7:0]  lat_q, lat_d;
    logic [31:0] res_q, res_d;
    logic [4:0]  flags_q, flags_d;
    logic        ack_q, ack_d;
    logic        err_q, err_d;
    logic        ovr_q, ovr_d;
    logic [7:0]  lat_out_q, lat_out_d;

    assign eff        = la_data_in & ~la_oenb;
    assign clr_req    = eff[CMD_CLR_BIT];
    assign busy       = (state_q != ST_IDLE);
    assign unused_eff = ^eff[LA_W-1:CMD_CLR_BIT+1];

    la_toggle_sync u_req_sync (
        .clk    (clk),
        .rst_l  (rst_l),
        .tog_in (eff[CMD_REQ_BIT]),
        .pulse  (req_pulse)
    );

    // Main transaction FSM; latency counts WAIT edges so it equals done-edge minus accept-edge
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        c_d       = c_q;
        op_d      = op_q;
        rm_d      = rm_q;
        valid_d   = valid_q;
        lat_d     = lat_q;
        res_d     = res_q;
        flags_d   = flags_q;
        ack_d     = ack_q;
        err_d     = err_q;
        lat_out_d = lat_out_q;
        lat_inc   = sat_inc8(lat_q);

        case (state_q)
            ST_IDLE: begin
                if (req_pulse) begin
                    a_d     = eff[CMD_A_LSB +: 32];
                    b_d     = eff[CMD_B_LSB +: 32];
                    c_d     = eff[CMD_C_LSB +: 32];
                    op_d    = eff[CMD_OP_LSB +: 4];
                    rm_d    = eff[CMD_RM_LSB +: 3];
                    valid_d = 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (fpu_ready) begin
                    valid_d = 1'b0;
                    lat_d   = 8'd0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                lat_d = lat_inc;
                if (fpu_done) begin
                    res_d   = fpu_result;
                    flags_d = fpu_flags;
                    err_d   = 1'b0;
                    state_d = ST_DONE;
                end else if (lat_inc == TIMEOUT_C) begin
                    res_d   = 32'd0;
                    flags_d = 5'd0;
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                ack_d     = ~ack_q;
                lat_out_d = lat_q;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // A request arriving while busy is dropped but remembered; a new drop beats a clear
    always_comb begin
        ovr_d = ovr_q;
        if (req_pulse && busy) begin
            ovr_d = 1'b1;
        end else if (clr_req) begin
            ovr_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q   <= ST_IDLE;
            a_q       <= 32'd0;
            b_q       <= 32'd0;
            c_q       <= 32'd0;
            op_q      <= 4'd0;
            rm_q      <= 3'd0;
            valid_q   <= 1'b0;
            lat_q     <= 8'd0;
            res_q     <= 32'd0;
            flags_q   <= 5'd0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            ovr_q     <= 1'b0;
            lat_out_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            c_q       <= c_d;
            op_q      <= op_d;
            rm_q      <= rm_d;
            valid_q   <= valid_d;
            lat_q     <= lat_d;
            res_q     <= res_d;
            flags_q   <= flags_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            ovr_q     <= ovr_d;
            lat_out_q <= lat_out_d;
        end
    end

    assign fpu_valid = valid_q;
    assign fpu_op    = op_q;
    assign fpu_rm    = rm_q;
    assign fpu_a     = a_q;
    assign fpu_b     = b_q;
    assign fpu_c     = c_q;

    // Response word is assembled purely from flops; unused bits stay zero
    always_comb begin
        la_data_out                         = '0;
        la_data_out[RSP_RES_LSB +: 32]      = res_q;
        la_data_out[RSP_FLAGS_LSB +: 5]     = flags_q;
        la_data_out[RSP_ACK_BIT]            = ack_q;
        la_data_out[RSP_BUSY_BIT]           = busy;
        la_data_out[RSP_ERR_BIT]            = err_q;
        la_data_out[RSP_OVR_BIT]            = ovr_q;
        la_data_out[RSP_LAT_LSB +: 8]       = lat_out_q;
    end

endmodule

// File: tb/tb_fpu_la_bridge.sv
// Directed bench for fpu_la_bridge with a behavioural FPU responder whose
// acceptance, latency, result and completion are set per scenario.
module tb_fpu_la_bridge;
    import fpu_la_pkg::*;

    logic         clk = 1'b0;
    logic         rst_l = 1'b0;
    logic [127:0] la_data_in = '0;
    logic [127:0] la_oenb = '0;
    logic [127:0] la_data_out;
    logic         fpu_valid;
    logic         fpu_ready = 1'b1;
    logic [3:0]   fpu_op;
    logic [2:0]   fpu_rm;
    logic [31:0]  fpu_a;
    logic [31:0]  fpu_b;
    logic [31:0]  fpu_c;
    logic         fpu_done;
    logic [31:0]  fpu_result;
    logic [4:0]   fpu_flags;

    int testsRun = 0;
    int testsFailed = 0;
    int cyc = 0;
    int reqEdge = 0;
    int ackEdge = 0;

    int          modelDelay = 3;
    bit          modelNeverDone = 1'b0;
    logic [31:0] modelResult = 32'd0;
    logic [4:0]  modelFlags = 5'd0;
    int          modelTxns = 0;
    int          waitCnt = 0;

    fpu_la_bridge #(.TIMEOUT(20)) dut (
        .clk         (clk),
        .rst_l       (rst_l),
        .la_data_in  (la_data_in),
        .la_oenb     (la_oenb),
        .la_data_out (la_data_out),
        .fpu_valid   (fpu_valid),
        .fpu_ready   (fpu_ready),
        .fpu_op      (fpu_op),
        .fpu_rm      (fpu_rm),
        .fpu_a       (fpu_a),
        .fpu_b       (fpu_b),
        .fpu_c       (fpu_c),
        .fpu_done    (fpu_done),
        .fpu_result  (fpu_result),
        .fpu_flags   (fpu_flags)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // FPU model: accepts on valid&ready, pulses done modelDelay edges later
    initial begin
        fpu_done   = 1'b0;
        fpu_result = 32'd0;
        fpu_flags  = 5'd0;
        forever begin
            @(negedge clk);
            fpu_done = 1'b0;
            if (!rst_l) begin
                waitCnt = 0;
            end else if (waitCnt > 0) begin
                waitCnt--;
                if (waitCnt == 0) begin
                    fpu_done   = 1'b1;
                    fpu_result = modelResult;
                    fpu_flags  = modelFlags;
                end
            end else if (fpu_valid && fpu_ready) begin
                modelTxns++;
                if (!modelNeverDone) waitCnt = modelDelay;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                                 input logic [3:0] op, input logic [2:0] rm);
        @(negedge clk);
        la_data_in[CMD_A_LSB +: 32] = a;
        la_data_in[CMD_B_LSB +: 32] = b;
        la_data_in[CMD_C_LSB +: 32] = c;
        la_data_in[CMD_OP_LSB +: 4] = op;
        la_data_in[CMD_RM_LSB +: 3] = rm;
        la_data_in[CMD_REQ_BIT]     = ~la_data_in[CMD_REQ_BIT];
        reqEdge = cyc + 1;
    endtask

    task automatic waitAck(input logic expAck, input int maxCycles);
        int n = 0;
        while (la_data_out[RSP_ACK_BIT] !== expAck && n < maxCycles) begin
            @(negedge clk);
            n++;
        end
        ackEdge = cyc;
        checkOutput("ack_arrived", la_data_out[RSP_ACK_BIT], expAck);
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base;
        logic [127:0] snap;

        $display("[TB] reset");
        repeat (3) @(negedge clk);
        checkOutput("reset_la_out", la_data_out, 128'd0);
        checkOutput("reset_valid", fpu_valid, 1'b0);
        checkOutput("reset_a", fpu_a, 32'd0);
        checkOutput("reset_op", fpu_op, 4'd0);
        rst_l = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("idle_no_req", fpu_valid, 1'b0);

        $display("[TB] add 1.0 + 2.0");
        modelResult = 32'h40400000;
        modelFlags  = 5'd0;
        applyStimulus(32'h3F800000, 32'h40000000, 32'd0, FPU_OP_ADD, FPU_RM_RNE);
        @(negedge clk);
        checkOutput("add_valid", fpu_valid, 1'b1);
        checkOutput("add_a", fpu_a, 32'h3F800000);
        checkOutput("add_b", fpu_b, 32'h40000000);
        checkOutput("add_op", fpu_op, 4'd0);
        waitAck(1'b1, 30);
        checkOutput("add_req_to_ack", 128'(ackEdge - reqEdge), 128'd5);
        checkOutput("add_result", la_data_out[31:0], 32'h40400000);
        checkOutput("add_flags", la_data_out[36:32], 5'd0);
        checkOutput("add_latency", la_data_out[55:48], 8'd3);
        checkOutput("add_busy", la_data_out[38], 1'b0);
        checkOutput("add_err", la_data_out[39], 1'b0);
        checkOutput("add_txns", 128'(modelTxns), 128'd1);

        $display("[TB] divide by zero");
        modelResult = 32'h7F800000;
        modelFlags  = 5'b01000;
        applyStimulus(32'h3F800000, 32'h00000000, 32'd0, FPU_OP_DIV, FPU_RM_RTZ);
        @(negedge clk);
        la_data_in[CMD_A_LSB +: 32] = 32'hDEADBEEF;
        la_data_in[CMD_OP_LSB +: 4] = 4'd9;
        @(negedge clk);
        checkOutput("div_a_held", fpu_a, 32'h3F800000);
        checkOutput("div_op_held", fpu_op, 4'd3);
        checkOutput("div_rm_held", fpu_rm, 3'd1);
        waitAck(1'b0, 30);
        checkOutput("div_result", la_data_out[31:0], 32'h7F800000);
        checkOutput("div_flags", la_data_out[36:32], 5'b01000);
        checkOutput("div_latency", la_data_out[55:48], 8'd3);

        $display("[TB] timeout");
        modelNeverDone = 1'b1;
        applyStimulus(32'h11111111, 32'h22222222, 32'h33333333, FPU_OP_FMA, FPU_RM_RNE);
        waitAck(1'b1, 60);
        checkOutput("to_err", la_data_out[39], 1'b1);
        checkOutput("to_result", la_data_out[31:0], 32'd0);
        checkOutput("to_flags", la_data_out[36:32], 5'd0);
        checkOutput("to_latency", la_data_out[55:48], 8'd20);
        checkOutput("to_busy", la_data_out[38], 1'b0);
        modelNeverDone = 1'b0;
        modelResult = 32'h40400000;
        modelFlags  = 5'd0;
        applyStimulus(32'h3F800000, 32'h40000000, 32'd0, FPU_OP_ADD, FPU_RM_RNE);
        waitAck(1'b0, 30);
        checkOutput("to_err_cleared", la_data_out[39], 1'b0);
        checkOutput("to_next_result", la_data_out[31:0], 32'h40400000);

        $display("[TB] overrun");
        modelDelay = 10;
        base = modelTxns;
        applyStimulus(32'h40000000, 32'h40000000, 32'd0, FPU_OP_MUL, FPU_RM_RNE);
        repeat (3) @(negedge clk);
        la_data_in[CMD_REQ_BIT] = 1'b0;
        @(negedge clk);
        la_data_in[CMD_REQ_BIT] = 1'b1;
        @(negedge clk);
        checkOutput("ovr_busy_set", la_data_out[40], 1'b1);
        waitAck(1'b1, 40);
        repeat (6) @(negedge clk);
        checkOutput("ovr_one_txn", 128'(modelTxns - base), 128'd1);
        checkOutput("ovr_sticky", la_data_out[40], 1'b1);
        checkOutput("ovr_idle", la_data_out[38], 1'b0);
        la_data_in[CMD_CLR_BIT] = 1'b1;
        @(negedge clk);
        la_data_in[CMD_CLR_BIT] = 1'b0;
        checkOutput("ovr_cleared", la_data_out[40], 1'b0);
        applyStimulus(32'h40000000, 32'h40000000, 32'd0, FPU_OP_MUL, FPU_RM_RNE);
        repeat (3) @(negedge clk);
        la_data_in[CMD_REQ_BIT] = 1'b1;
        la_data_in[CMD_CLR_BIT] = 1'b1;
        @(negedge clk);
        la_data_in[CMD_CLR_BIT] = 1'b0;
        checkOutput("ovr_set_beats_clr", la_data_out[40], 1'b1);
        la_data_in[CMD_REQ_BIT] = 1'b0;
        waitAck(1'b0, 40);
        modelDelay = 3;

        $display("[TB] oenb masking");
        @(negedge clk);
        la_oenb = '1;
        @(negedge clk);
        snap = la_data_out;
        base = modelTxns;
        la_data_in[CMD_REQ_BIT] = 1'b1;
        repeat (8) @(negedge clk);
        checkOutput("oenb_out_same", la_data_out, snap);
        checkOutput("oenb_valid", fpu_valid, 1'b0);
        checkOutput("oenb_no_txn", 128'(modelTxns - base), 128'd0);
        la_data_in[CMD_REQ_BIT] = 1'b0;
        @(negedge clk);
        la_oenb = '0;

        $display("[TB] reset during wait");
        modelDelay = 10;
        applyStimulus(32'h3F800000, 32'h3F800000, 32'd0, FPU_OP_SUB, FPU_RM_RNE);
        repeat (4) @(negedge clk);
        checkOutput("rst_pre_busy", la_data_out[38], 1'b1);
        #2;
        rst_l = 1'b0;
        #1;
        checkOutput("rst_async_out", la_data_out, 128'd0);
        checkOutput("rst_async_valid", fpu_valid, 1'b0);
        repeat (2) @(negedge clk);
        modelDelay = 3;
        base = modelTxns;
        rst_l = 1'b1;
        waitAck(1'b1, 30);
        repeat (8) @(negedge clk);
        checkOutput("rst_one_new_txn", 128'(modelTxns - base), 128'd1);
        checkOutput("rst_post_idle", la_data_out[38], 1'b0);
        checkOutput("rst_post_latency", la_data_out[55:48], 8'd3);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
